uart_matrix_loader: RTL
=======================

Name: uart_matrix_loader

Overview:
- Consumes the byte stream from the UART receiver (one-cycle `valid` strobe plus 8-bit data) and unpacks framed matrix operands into element write commands for the two operand buffers of the matrix multiplier.
- Frame format: SYNC byte 0xA5, then N*N bytes of matrix A in row-major order, then N*N bytes of matrix B in row-major order.
- Signals completion to the multiplier with a one-cycle `done` pulse.
- Aborts a frame on a bad sync byte or on an inter-byte timeout.

Parameters:
- N, 2, matrix dimension; legal range N >= 2.
- DATA_W, 8, element width; equals the UART byte width.
- TIMEOUT_CYC, 100000, idle clk cycles allowed between bytes inside a frame before the frame is aborted.
- IDX_W, $clog2(N), row/column index width; derived, not overridable.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- in_data  input  DATA_W  received byte from the UART receiver.
- in_valid  input  1  one-cycle strobe, one byte per high cycle; back-to-back strobes are legal.
- mat_ready  input  1  multiplier idle; a new frame is accepted only while this is high.
- wr_en  output  1  element write strobe.
- wr_sel  output  1  target buffer: 0 = A, 1 = B.
- wr_row  output  IDX_W  element row index.
- wr_col  output  IDX_W  element column index.
- wr_data  output  DATA_W  element value.
- busy  output  1  high while in LOAD_A or LOAD_B.
- done  output  1  one-cycle pulse after the last B element is written.
- err  output  1  one-cycle error pulse.
- err_code  output  2  valid only while err is high: 01 = bad sync, 10 = timeout.

Behaviour:
- Reset: state IDLE; all outputs 0; row/col counters and timeout counter cleared.
- rst wins over every other event.
- Reset mid-frame abandons the frame: no done, no err. Elements already written remain in the buffers.
- All outputs are registered. Write latency is 1: wr_en is high in the cycle after the accepted in_valid.
- wr_en is low in every cycle that does not follow an accepted byte.
- States: IDLE, LOAD_A, LOAD_B, DONE.
- IDLE:
  - in_valid and mat_ready=0: byte dropped, no error.
  - in_valid, mat_ready=1, in_data=0xA5: go to LOAD_A; row=col=0; timeout counter cleared.
  - in_valid, mat_ready=1, in_data!=0xA5: err=1 with err_code=01 next cycle; remain in IDLE.
- LOAD_A / LOAD_B, on each in_valid:
  - Issue a write with wr_sel = 0 or 1, the current row/col, and wr_data = in_data.
  - col increments; at col=N-1 it wraps to 0 and row increments.
- LOAD_A: the byte accepted at (N-1, N-1) moves to LOAD_B with row=col=0.
- LOAD_B: the byte accepted at (N-1, N-1) moves to DONE.
- DONE lasts exactly one cycle:
  - done=1 in the cycle after the final wr_en; return to IDLE.
  - An in_valid arriving during DONE is dropped, even if it is 0xA5; no error.
- A 0xA5 byte inside LOAD_A/LOAD_B is ordinary data, not a resync.
- mat_ready is sampled only in IDLE; it does not affect a frame once started.
- Timeout (LOAD_A/LOAD_B only):
  - Counter clears on every in_valid and increments otherwise.
  - When it reaches TIMEOUT_CYC-1 with no in_valid that cycle: err=1 with err_code=10 next cycle; go to IDLE; busy drops in the same cycle err rises.
  - in_valid in the same cycle the counter reaches TIMEOUT_CYC-1: the byte wins and the counter clears.
  - Counter width is $clog2(TIMEOUT_CYC); saturation is not needed because the abort fires first.
- busy is 1 in the cycle following entry into LOAD_A and stays high until the cycle after leaving LOAD_B or aborting.
- done and err are never high in the same cycle.
- Exactly 2*N*N wr_en pulses occur per completed frame.

Decomposition:
- Package uart_matrix_pkg:
  - SYNC_BYTE = 8'hA5.
  - State enum {IDLE, LOAD_A, LOAD_B, DONE}.
  - Error codes ERR_SYNC = 2'b01, ERR_TIMEOUT = 2'b10.
  - Buffer select constants SEL_A = 1'b0, SEL_B = 1'b1.
- Sub-module mat_index_counter:
  - Row-major row/col counter with clear, advance, and a combinational `last` flag at (N-1, N-1).
  - One instance, cleared on entry to LOAD_A and LOAD_B.

Test Plan (N=2, TIMEOUT_CYC=16):
- Reset: hold rst 3 cycles with in_valid toggling -> all outputs 0 throughout and on the first cycle after release.
- Full frame, back-to-back strobes, mat_ready=1, bytes A5,01,02,03,04,05,06,07,08 -> writes A(0,0)=01, A(0,1)=02, A(1,0)=03, A(1,1)=04, B(0,0)=05 … B(1,1)=08; exactly 8 wr_en; done is a single pulse one cycle after the B(1,1) write; busy then low.
- Bad sync: byte 3C in IDLE -> err=1, err_code=01 for one cycle; no wr_en. A following A5 frame completes normally.
- Timeout: A5,01,02 then 16 idle cycles -> err=1, err_code=10 once; busy=0. A later byte 03 produces no wr_en (treated as bad sync, err_code=01).
- mat_ready=0, then byte A5 -> no busy, no err, no wr_en. Raise mat_ready and resend the frame -> completes.
- rst pulsed after the B(0,0) write -> no done, no err; busy=0. A fresh frame then writes all 8 elements starting from A(0,0).

Source files
------------

// File: rtl/uart_matrix_pkg.sv
// Shared constants and types for the UART-to-matrix operand loader.
// Sync byte, FSM states, error codes and operand buffer selects.
package uart_matrix_pkg;

    localparam int unsigned ERR_W = 2;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [ERR_W-1:0] ERR_NONE    = 2'b00;
    localparam logic [ERR_W-1:0] ERR_SYNC    = 2'b01;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'b10;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/uart_matrix_loader_if.sv
// Byte-stream input and element-write/status bus of the matrix loader.
// The loader is the slave side; the UART receiver / multiplier side is the master.
interface uart_matrix_loader_if #(
    parameter int unsigned N      = 2,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned IDX_W = $clog2(N);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              mat_ready;
    logic              wr_en;
    logic              wr_sel;
    logic [IDX_W-1:0]  wr_row;
    logic [IDX_W-1:0]  wr_col;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    modport master (
        output in_data, in_valid, mat_ready,
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, busy, done, err, err_code
    );

    modport slave (
        input  in_data, in_valid, mat_ready,
        output wr_en, wr_sel, wr_row, wr_col, wr_data, busy, done, err, err_code
    );

endinterface

// File: rtl/mat_index_counter.sv
// Row-major (row, col) element counter over an N x N matrix.
// last_c flags the final element (N-1, N-1); advancing past it wraps to (0, 0).
module mat_index_counter #(
    parameter  int unsigned N     = 2,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             last_c
);

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            if (col == IDX_MAX) begin
                col <= '0;
                row <= (row == IDX_MAX) ? '0 : row + IDX_W'(1);
            end else begin
                col <= col + IDX_W'(1);
            end
        end
    end

    assign last_c = (row == IDX_MAX) && (col == IDX_MAX);

endmodule

// File: rtl/uart_matrix_loader.sv
// Unpacks SYNC + A(NxN) + B(NxN) byte frames into operand-buffer element writes.
// Aborts on a bad sync byte or an inter-byte timeout; pulses done after the last B write.
module uart_matrix_loader
    import uart_matrix_pkg::*;
#(
    parameter int unsigned N           = 2,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input logic                 clk,
    input logic                 rst,
    uart_matrix_loader_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    state_t state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;

    logic             idx_clr, idx_adv, idx_last_c;
    logic [IDX_W-1:0] idx_row, idx_col;

    logic              wr_en_q,   wr_en_nxt;
    logic              wr_sel_q,  wr_sel_nxt;
    logic [IDX_W-1:0]  wr_row_q,  wr_row_nxt;
    logic [IDX_W-1:0]  wr_col_q,  wr_col_nxt;
    logic [DATA_W-1:0] wr_data_q, wr_data_nxt;
    logic              busy_q,    busy_nxt;
    logic              done_q,    done_nxt;
    logic              err_q,     err_nxt;
    logic [ERR_W-1:0]  err_code_q, err_code_nxt;

    mat_index_counter #(.N(N)) u_idx (
        .clk    (clk),
        .rst    (rst),
        .clr    (idx_clr),
        .adv    (idx_adv),
        .row    (idx_row),
        .col    (idx_col),
        .last_c (idx_last_c)
    );

    // State, timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tmr        <= '0;
            wr_en_q    <= 1'b0;
            wr_sel_q   <= 1'b0;
            wr_row_q   <= '0;
            wr_col_q   <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state      <= state_nxt;
            tmr        <= tmr_nxt;
            wr_en_q    <= wr_en_nxt;
            wr_sel_q   <= wr_sel_nxt;
            wr_row_q   <= wr_row_nxt;
            wr_col_q   <= wr_col_nxt;
            wr_data_q  <= wr_data_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            err_q      <= err_nxt;
            err_code_q <= err_code_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt    = state;
        tmr_nxt      = tmr;
        idx_clr      = 1'b0;
        idx_adv      = 1'b0;
        wr_en_nxt    = 1'b0;
        wr_sel_nxt   = wr_sel_q;
        wr_row_nxt   = wr_row_q;
        wr_col_nxt   = wr_col_q;
        wr_data_nxt  = wr_data_q;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        err_code_nxt = ERR_NONE;

        unique case (state)
            IDLE: begin
                if (bus.in_valid && bus.mat_ready) begin
                    if (bus.in_data == DATA_W'(SYNC_BYTE)) begin
                        state_nxt = LOAD_A;
                        idx_clr   = 1'b1;
                        tmr_nxt   = '0;
                    end else begin
                        err_nxt      = 1'b1;
                        err_code_nxt = ERR_SYNC;
                    end
                end
            end

            LOAD_A, LOAD_B: begin
                if (bus.in_valid) begin
                    // A byte always wins over a timeout expiring in the same cycle.
                    wr_en_nxt   = 1'b1;
                    wr_sel_nxt  = (state == LOAD_B) ? SEL_B : SEL_A;
                    wr_row_nxt  = idx_row;
                    wr_col_nxt  = idx_col;
                    wr_data_nxt = bus.in_data;
                    tmr_nxt     = '0;
                    if (idx_last_c) begin
                        state_nxt = (state == LOAD_A) ? LOAD_B : DONE;
                        idx_clr   = 1'b1;
                    end else begin
                        idx_adv = 1'b1;
                    end
                end else if (tmr == TMR_LAST) begin
                    state_nxt    = IDLE;
                    tmr_nxt      = '0;
                    err_nxt      = 1'b1;
                    err_code_nxt = ERR_TIMEOUT;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end

            DONE: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end

            default: state_nxt = IDLE;
        endcase
    end

    assign busy_nxt = (state_nxt == LOAD_A) || (state_nxt == LOAD_B);

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_sel   = wr_sel_q;
    assign bus.wr_row   = wr_row_q;
    assign bus.wr_col   = wr_col_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;

endmodule
